// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one registered magnitude comparator between NUM_REQ requesters.
// Build macro CMP_SIGNED_EN selects a two's-complement compare; the default build compares unsigned.
module cmp_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic                       rsp_gt,
    output logic                       rsp_eq,
    output logic                       rsp_lt,
    output logic                       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    // Returns {gt, eq, lt}; exactly one bit is set for any operand pair.
    function automatic logic [2:0] cmp_flags(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
`ifdef CMP_SIGNED_EN
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return {sa > sb, sa == sb, sa < sb};
`else
        return {a > b, a == b, a < b};
`endif
    endfunction

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic [IDW-1:0]       op_id_q, op_id_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [2:0]           rsp_flags_q, rsp_flags_d;

    logic [NUM_REQ-1:0]   gnt_oh;
    logic                 gnt_found;
    logic [IDW-1:0]       gnt_id;
    logic [WIDTH-1:0]     gnt_a;
    logic [WIDTH-1:0]     gnt_b;
    logic [IDW-1:0]       idx_sel;
    int                   idx;

    // Stage 0: rotating priority search starting at rr_ptr
    always_comb begin
        gnt_oh    = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        idx       = 0;
        idx_sel   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_sel = IDW'(idx);
            if (!gnt_found && req_valid[idx_sel]) begin
                gnt_found       = 1'b1;
                gnt_oh[idx_sel] = 1'b1;
                gnt_id          = idx_sel;
                gnt_a           = req_a[idx*WIDTH +: WIDTH];
                gnt_b           = req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE && !rst) ? gnt_oh : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_id_d    = rsp_id_q;
        rsp_flags_d = rsp_flags_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    op_a_d  = gnt_a;
                    op_b_d  = gnt_b;
                    op_id_d = gnt_id;
                    state_d = ST_COMPARE;
                end
            end
            // Stage 1: compare captured operands into the response registers
            ST_COMPARE: begin
                rsp_flags_d = cmp_flags(op_a_q, op_b_q);
                rsp_id_d    = op_id_q;
                state_d     = ST_RESP;
            end
            // Stage 2: hold the response; the served requester drops to lowest priority
            ST_RESP: begin
                if (rsp_ready) begin
                    if (rsp_id_q == IDW'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = rsp_id_q + 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rsp_id_q    <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_id_q    <= rsp_id_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_gt    = rsp_flags_q[2];
    assign rsp_eq    = rsp_flags_q[1];
    assign rsp_lt    = rsp_flags_q[0];
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level reference model.
module tb_cmp_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 2;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_gt;
    logic             rsp_eq;
    logic             rsp_lt;
    logic             busy;

    always #5 clk = ~clk;

    cmp_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_eq    (rsp_eq),
        .rsp_lt    (rsp_lt),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = waiting for a grant, 1 = compare pending, 2 = response offered
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_id    = 0;
    int         m_a     = 0;
    int         m_b     = 0;
    int         m_rid   = 0;
    logic [2:0] m_flags = 3'b000;
    logic [N-1:0] last_xfer = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input int a, input int b);
        int sa;
        int sb;
        sa = a;
        sb = b;
`ifdef CMP_SIGNED_EN
        if (sa >= (1 << (W - 1))) sa = sa - (1 << W);
        if (sb >= (1 << (W - 1))) sb = sb - (1 << W);
`endif
        return {sa > sb, sa == sb, sa < sb};
    endfunction

    function automatic int ref_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic probe();
        int g;
        logic [31:0] exp_rdy;
        #1;
        g = ref_grant();
        exp_rdy = (m_phase == 0 && !rst && g >= 0) ? (32'd1 << g) : 32'd0;
        chk("req_ready", 32'(req_ready), exp_rdy);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("rsp_id", 32'(rsp_id), m_rid);
        chk("rsp_flags", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'(m_flags));
    endtask

    task automatic tick();
        int g;
        last_xfer = req_valid & req_ready;
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
            m_rid   = 0;
            m_flags = 3'b000;
        end else begin
            case (m_phase)
                0: begin
                    g = ref_grant();
                    if (g >= 0) begin
                        m_id    = g;
                        m_a     = int'(req_a >> (g * W)) & ((1 << W) - 1);
                        m_b     = int'(req_b >> (g * W)) & ((1 << W) - 1);
                        m_phase = 1;
                    end
                end
                1: begin
                    m_rid   = m_id;
                    m_flags = ref_cmp(m_a, m_b);
                    m_phase = 2;
                end
                default: begin
                    if (rsp_ready) begin
                        m_ptr   = (m_id + 1) % N;
                        m_phase = 0;
                    end
                end
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        probe();
        tick();
    endtask

    task automatic set_random_inputs();
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && !last_xfer[i]) begin
                if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
            end else begin
                req_valid[i]     = 1'($urandom_range(1));
                req_a[i*W +: W]  = W'($urandom);
                req_b[i*W +: W]  = W'($urandom);
            end
        end
        rsp_ready = ($urandom_range(3) != 0);
        rst       = ($urandom_range(199) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int gc[8];
        int gi[8];
        int ng;
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(negedge clk);

        // Reset held with every requester valid
        step();
        step();

        // Single request from requester 2: A=3, B=1
        rst       = 1'b0;
        req_valid = 4'b0100;
        req_a     = 8'b00_11_00_00;
        req_b     = 8'b00_01_00_00;
        rsp_ready = 1'b1;
        probe();
        chk("single_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        step();
        probe();
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd2);
`ifdef CMP_SIGNED_EN
        chk("single_flags", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'b001);
`else
        chk("single_flags", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'b100);
`endif
        tick();
        probe();
        chk("single_held_once", 32'(rsp_valid), 32'd0);
        tick();

        // Round-robin with all requesters valid
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 15; c++) begin
            probe();
            if (req_ready != '0 && ng < 8) begin
                gc[ng] = c;
                gi[ng] = onehot_idx(req_ready);
                ng++;
            end
            tick();
        end
        chk("rr_count", 32'(ng), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", 32'(gi[k]), 32'(k % N));
            chk("rr_spacing", 32'(gc[k]), 32'(3 * k));
        end

        // Backpressure: requester 1 with A=0, B=2
        req_valid = 4'b0010;
        req_a     = 8'b00_00_00_00;
        req_b     = 8'b00_00_10_00;
        rsp_ready = 1'b0;
        probe();
        chk("bp_grant", 32'(req_ready), 32'h2);
        tick();
        step();
        for (int c = 0; c < 5; c++) begin
            probe();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
`ifdef CMP_SIGNED_EN
            chk("bp_flags", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'b100);
`else
            chk("bp_flags", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'b001);
`endif
            chk("bp_no_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        probe();
        chk("bp_release_valid", 32'(rsp_valid), 32'd1);
        tick();
        probe();
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        tick();

        // Reset while the response is offered
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        probe();
        chk("rstresp_valid", 32'(rsp_valid), 32'd1);
        tick();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 4'b1010;
        probe();
        chk("rstresp_dropped", 32'(rsp_valid), 32'd0);
        chk("rstresp_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        step();

        // Operand sweep through requester 0
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                req_valid = 4'b0001;
                req_a     = 8'(a);
                req_b     = 8'(b);
                probe();
                chk("sweep_grant", 32'(req_ready), 32'h1);
                tick();
                req_valid = '0;
                step();
                probe();
                chk("sweep_eq", 32'(rsp_eq), 32'(a == b));
                if (a == 2 && b == 1) begin
`ifdef CMP_SIGNED_EN
                    chk("sweep_2v1", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'b001);
`else
                    chk("sweep_2v1", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'b100);
`endif
                end
                tick();
            end
        end

        // Randomized traffic with backpressure and occasional reset
        last_xfer = '0;
        for (int c = 0; c < 3000; c++) begin
            set_random_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
